// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MEM pipeline stage: WB control bit positions,
//   the data-memory port FSM state encoding and the MEM/WB bubble values.
package mips_pkg;

   // Bit positions inside the 2-bit WB control field
   localparam int WB_REGW    = 1;   // register write enable
   localparam int WB_MEM2REG = 0;   // write-back source is memory (load)

   // Data-memory port FSM
   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_t;

   // Values loaded into MEM/WB when a bubble is inserted
   localparam logic [1:0]  BUBBLE_WB   = 2'b00;
   localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;
   localparam logic [4:0]  BUBBLE_REG  = 5'd0;

endpackage

// File: rtl/dmem_port_fsm.sv
// dmem_port_fsm
//   Request/acknowledge sequencer for the data-memory port. Holds the pipe
//   while an access is outstanding and abandons it after TIMEOUT wait cycles.
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   i_mem_op       current EX/MEM slot needs a memory access
//   i_ack          memory completed the access this cycle
//   o_req          memory request
//   o_stall        hold the upstream pipeline this cycle
//   o_timeout      this edge abandons the access (MEM/WB must take a bubble)
//   o_err          sticky flag: some access timed out
module dmem_port_fsm
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic i_mem_op,
   input  logic i_ack,
   output logic o_req,
   output logic o_stall,
   output logic o_timeout,
   output logic o_err
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   mem_state_t r_state;
   mem_state_t w_state_next;
   logic [7:0] r_cnt;
   logic       r_err;
   logic       w_at_limit;

   assign w_at_limit = (r_state == S_WAIT) && (r_cnt == LIMIT);

   // State register, wait counter and sticky error flag
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE) begin
            if (i_mem_op && !i_ack)
               r_cnt <= 8'd1;
         end else if (!i_ack) begin
            if (w_at_limit)
               r_err <= 1'b1;
            else
               r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_mem_op && !i_ack) w_state_next = S_WAIT;
         S_WAIT:  if (i_ack || w_at_limit) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Outputs; the request is suppressed during reset even when caught mid-WAIT
   always_comb begin
      o_req = 1'b0;
      case (r_state)
         S_IDLE:  o_req = i_mem_op;
         S_WAIT:  o_req = 1'b1;
         default: o_req = 1'b0;
      endcase
      if (reset)
         o_req = 1'b0;
      o_stall   = i_mem_op && !i_ack && !w_at_limit;
      o_timeout = w_at_limit && !i_ack;
      o_err     = r_err;
   end

endmodule

// File: rtl/stage_mem.sv
// stage_mem
//   MEM pipeline stage. Resolves branches/jumps for IF, drives the data-memory
//   port (through dmem_port_fsm) for loads/stores, stalls while memory is busy,
//   and registers the MEM/WB pipeline register.
// Ports
//   clock, reset                     clock, synchronous active-high reset
//   nop_i, wbi, M, alu_in,           EX/MEM register contents
//   store_data, regaddr, is_jump,
//   branch_eq, branch_inc, zero,
//   jump_address
//   dmem_req/we/addr/wdata           data-memory request side
//   dmem_rdata/ack                   data-memory response side
//   pc_src_o, pc_target_o, flush_o   branch resolution toward IF
//   stall_o                          hold PC, IF/ID, ID/EX, EX/MEM
//   fwd_mem_o                        MEM-stage forwarding value to EX
//   wb_o, mem_data_o, alu_out_o,     MEM/WB register
//   regaddr_o, nop_o
//   err_o                            sticky memory-timeout flag
module stage_mem
   import mips_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              nop_i,
   input  logic [1:0]        wbi,
   input  logic              M,
   input  logic [31:0]       alu_in,
   input  logic [31:0]       store_data,
   input  logic [4:0]        regaddr,
   input  logic              is_jump,
   input  logic              branch_eq,
   input  logic              branch_inc,
   input  logic              zero,
   input  logic [31:0]       jump_address,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              pc_src_o,
   output logic [31:0]       pc_target_o,
   output logic              flush_o,
   output logic              stall_o,
   output logic [31:0]       fwd_mem_o,
   output logic [1:0]        wb_o,
   output logic [31:0]       mem_data_o,
   output logic [31:0]       alu_out_o,
   output logic [4:0]        regaddr_o,
   output logic              nop_o,
   output logic              err_o
);

   logic w_mem_op;
   logic w_load;
   logic w_stall;
   logic w_timeout;

   // Store wins if both M and mem-to-reg are set, so a load requires !M
   assign w_mem_op = !nop_i && (M || wbi[WB_MEM2REG]);
   assign w_load   = !nop_i && wbi[WB_MEM2REG] && !M;

   dmem_port_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_port (
      .clock     (clock),
      .reset     (reset),
      .i_mem_op  (w_mem_op),
      .i_ack     (dmem_ack),
      .o_req     (dmem_req),
      .o_stall   (w_stall),
      .o_timeout (w_timeout),
      .o_err     (err_o)
   );

   // Word access: the byte offset bits of the address are dropped
   assign dmem_we     = M;
   assign dmem_addr   = alu_in[ADDR_W+1:2];
   assign dmem_wdata  = store_data;

   assign pc_src_o    = !nop_i && (is_jump || (branch_eq && zero) || (branch_inc && !zero));
   assign pc_target_o = jump_address;
   assign flush_o     = pc_src_o;
   assign stall_o     = w_stall;
   assign fwd_mem_o   = alu_in;

   // MEM/WB register; stalls and abandoned accesses both leave a bubble
   always_ff @(posedge clock) begin
      if (reset || w_stall || w_timeout) begin
         wb_o       <= BUBBLE_WB;
         mem_data_o <= BUBBLE_WORD;
         alu_out_o  <= BUBBLE_WORD;
         regaddr_o  <= BUBBLE_REG;
         nop_o      <= 1'b1;
      end else begin
         wb_o       <= wbi;
         mem_data_o <= (w_load && dmem_ack) ? dmem_rdata : BUBBLE_WORD;
         alu_out_o  <= alu_in;
         regaddr_o  <= regaddr;
         nop_o      <= nop_i;
      end
   end

endmodule
